// File: rtl/jpeg_mcu_sequencer.sv
// MCU control sequencer for NUM_CH parallel encoder lanes: derives all lane strobes from the
// pixel handshake, buffers each lane's Huffman codes and merges them lane by lane into one stream.
module jpeg_mcu_sequencer #(
  parameter int NUM_CH     = 3,
  parameter int DCT_CYCLES = 16,
  parameter int ZZ_ROWS    = 8,
  parameter int CODE_W     = 16,
  parameter int LEN_W      = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  output logic                     input_1pix_enable,
  output logic                     dct_enable,
  output logic                     dct_end_enable,
  output logic                     zigzag_input_enable,
  output logic                     zigag_enable,
  output logic [7:0]               matrix_row,
  output logic                     Huffman_start,
  input  logic [NUM_CH-1:0]        ch_valid,
  input  logic [NUM_CH-1:0]        ch_last,
  input  logic [NUM_CH*CODE_W-1:0] ch_code,
  input  logic [NUM_CH*LEN_W-1:0]  ch_len,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CODE_W-1:0]        out_code,
  output logic [LEN_W-1:0]         out_len,
  output logic [1:0]               out_ch,
  output logic                     out_last,
  output logic                     busy,
  output logic [15:0]              mcu_count,
  output logic [NUM_CH-1:0]        err_overflow
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_DCT  = 3'd2;
  localparam logic [2:0] S_ZZ   = 3'd3;
  localparam logic [2:0] S_HUFF = 3'd4;

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam int          EW       = 1 + LEN_W + CODE_W;
  localparam logic [1:0]  LAST_CH  = 2'(NUM_CH - 1);
  localparam logic [15:0] DCT_LAST = 16'(DCT_CYCLES - 1);
  localparam logic [15:0] ZZ_LAST  = 16'(ZZ_ROWS);

  logic [2:0]  state_reg, state_next;
  logic [15:0] cyc_reg, cyc_next;
  logic [5:0]  pix_cnt_reg;
  logic [1:0]  cur_ch_reg;
  logic [15:0] mcu_count_reg;
  logic        pix_ready_reg, dct_enable_reg, dct_end_reg, zz_input_reg, zig_reg, huff_start_reg;
  logic [7:0]  matrix_row_reg;
  logic        mcu_done, out_hs, sel_valid, sel_last;
  logic [EW-1:0] sel_ent;
  logic [EW-1:0] head_ent [NUM_CH];
  logic [NUM_CH-1:0] fifo_empty;

  assign pix_ready           = pix_ready_reg;
  assign input_1pix_enable   = pix_valid & pix_ready_reg;
  assign dct_enable          = dct_enable_reg;
  assign dct_end_enable      = dct_end_reg;
  assign zigzag_input_enable = zz_input_reg;
  assign zigag_enable        = zig_reg;
  assign matrix_row          = matrix_row_reg;
  assign Huffman_start       = huff_start_reg;
  assign busy                = (state_reg != S_IDLE);
  assign mcu_count           = mcu_count_reg;

  always_comb begin
    state_next = state_reg;
    mcu_done   = 1'b0;
    case (state_reg)
      S_IDLE: if (enable) state_next = S_LOAD;
      S_LOAD: if (input_1pix_enable && pix_cnt_reg == 6'd63) state_next = S_DCT;
      S_DCT:  if (cyc_reg == DCT_LAST) state_next = S_ZZ;
      S_ZZ:   if (cyc_reg == ZZ_LAST) state_next = S_HUFF;
      S_HUFF: if (out_hs && out_last) begin
        mcu_done   = 1'b1;
        state_next = enable ? S_LOAD : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    // Phase-relative cycle index restarts on every state change.
    cyc_next = (state_next == state_reg) ? cyc_reg + 16'd1 : 16'd0;
  end

  // Strobes are computed from the next state so they line up with the state they belong to.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= S_IDLE;
      cyc_reg        <= '0;
      pix_cnt_reg    <= '0;
      pix_ready_reg  <= 1'b0;
      dct_enable_reg <= 1'b0;
      dct_end_reg    <= 1'b0;
      zz_input_reg   <= 1'b0;
      zig_reg        <= 1'b0;
      matrix_row_reg <= '0;
      huff_start_reg <= 1'b0;
      mcu_count_reg  <= '0;
      cur_ch_reg     <= '0;
    end else begin
      state_reg      <= state_next;
      cyc_reg        <= cyc_next;
      if (input_1pix_enable) pix_cnt_reg <= pix_cnt_reg + 6'd1;
      pix_ready_reg  <= (state_next == S_LOAD);
      dct_enable_reg <= (state_next == S_DCT) && (cyc_next == 16'd0);
      dct_end_reg    <= (state_next == S_DCT) && (cyc_next == DCT_LAST);
      zz_input_reg   <= (state_next == S_ZZ) && (cyc_next == 16'd0);
      zig_reg        <= (state_next == S_ZZ) && (cyc_next != 16'd0);
      matrix_row_reg <= ((state_next == S_ZZ) && (cyc_next != 16'd0)) ? 8'(cyc_next - 16'd1) : 8'd0;
      huff_start_reg <= (state_next == S_HUFF) && (cyc_next == 16'd0);
      if (mcu_done) mcu_count_reg <= mcu_count_reg + 16'd1;
      if (out_hs && sel_last) cur_ch_reg <= (cur_ch_reg == LAST_CH) ? 2'd0 : cur_ch_reg + 2'd1;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
      logic [EW-1:0] mem [FIFO_DEPTH];
      logic [AW:0]   wr_ptr_reg, rd_ptr_reg;
      logic          err_reg, full, push, pop, wr_ok;

      assign pop   = out_hs && (cur_ch_reg == 2'(gi));
      assign push  = ch_valid[gi];
      assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) && (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
      // A pop in the same cycle frees the slot the write lands in.
      assign wr_ok = push && (!full || pop);
      assign fifo_empty[gi]   = (wr_ptr_reg == rd_ptr_reg);
      assign head_ent[gi]     = mem[rd_ptr_reg[AW-1:0]];
      assign err_overflow[gi] = err_reg;

      always_ff @(posedge clock) begin
        if (wr_ok) mem[wr_ptr_reg[AW-1:0]] <= {ch_last[gi], ch_len[gi*LEN_W +: LEN_W], ch_code[gi*CODE_W +: CODE_W]};
      end

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          err_reg    <= 1'b0;
        end else begin
          if (wr_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
          if (push && full && !pop) err_reg <= 1'b1;
        end
      end
    end
  endgenerate

  always_comb begin
    sel_ent   = '0;
    sel_valid = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cur_ch_reg == 2'(i)) begin
        sel_ent   = head_ent[i];
        sel_valid = !fifo_empty[i];
      end
    end
  end

  assign sel_last  = sel_ent[EW-1];
  assign out_hs    = sel_valid && out_ready;
  assign out_valid = sel_valid;
  assign out_code  = sel_valid ? sel_ent[CODE_W-1:0] : '0;
  assign out_len   = sel_valid ? sel_ent[CODE_W +: LEN_W] : '0;
  assign out_ch    = cur_ch_reg;
  assign out_last  = sel_valid && sel_last && (cur_ch_reg == LAST_CH);
endmodule

// File: tb/tb_jpeg_mcu_sequencer.sv
// Randomized bench for jpeg_mcu_sequencer: a timeline/queue model checks every cycle, and
// directed MCUs pin the strobe schedule, merge order and overflow behaviour with literal values.
module tb_jpeg_mcu_sequencer;
  localparam int NCH = 3, DCT = 16, ZZR = 8, DEPTH = 16;

  logic clock = 1'b0, reset_n = 1'b0, enable = 1'b0, pix_valid = 1'b0, out_ready = 1'b0;
  logic [2:0]  ch_valid = '0, ch_last = '0;
  logic [47:0] ch_code = '0;
  logic [23:0] ch_len = '0;
  logic pix_ready, input_1pix_enable, dct_enable, dct_end_enable, zigzag_input_enable;
  logic zigag_enable, Huffman_start, out_valid, out_last, busy;
  logic [7:0]  matrix_row, out_len;
  logic [15:0] out_code, mcu_count;
  logic [1:0]  out_ch;
  logic [2:0]  err_overflow;

  always #5 clock = ~clock;

  jpeg_mcu_sequencer #(.NUM_CH(NCH), .DCT_CYCLES(DCT), .ZZ_ROWS(ZZR), .CODE_W(16), .LEN_W(8),
                       .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .input_1pix_enable(input_1pix_enable), .dct_enable(dct_enable),
    .dct_end_enable(dct_end_enable), .zigzag_input_enable(zigzag_input_enable),
    .zigag_enable(zigag_enable), .matrix_row(matrix_row), .Huffman_start(Huffman_start),
    .ch_valid(ch_valid), .ch_last(ch_last), .ch_code(ch_code), .ch_len(ch_len),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code), .out_len(out_len),
    .out_ch(out_ch), .out_last(out_last), .busy(busy), .mcu_count(mcu_count),
    .err_overflow(err_overflow));

  int n_vec = 0, n_err = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Model: LOAD counts beats, afterwards everything is an offset from the first post-load cycle.
  bit          m_loading = 0, m_post = 0;
  int          m_acc = 0, m_off = 0, m_cur = 0;
  logic [15:0] m_mcu = '0;
  logic [2:0]  m_err = '0;
  logic [24:0] mq [NCH][$];

  int cyc = 0, r_in1 = 0, r_ready = 0, r_last_ready = 0, r_dct = 0, r_dctend = 0;
  int r_zz = 0, r_zig = 0, r_huff = 0;
  logic [63:0] r_rows = '0;
  logic [18:0] cap [$];

  always @(negedge clock) begin
    logic [24:0] head;
    logic [7:0]  e_row;
    logic        e_valid, e_last, e_zig, hs;
    cyc++;
    if (!reset_n) begin
      m_loading = 0; m_post = 0; m_acc = 0; m_off = 0; m_cur = 0; m_mcu = '0; m_err = '0;
      for (int i = 0; i < NCH; i++) mq[i].delete();
    end
    e_zig = m_post && m_off >= DCT + 1 && m_off <= DCT + ZZR;
    e_row = e_zig ? 8'(m_off - DCT - 1) : 8'd0;
    chk("ctrl", {pix_ready, input_1pix_enable, dct_enable, dct_end_enable, zigzag_input_enable,
                 zigag_enable, matrix_row, Huffman_start, busy},
        {m_loading, m_loading && pix_valid, m_post && m_off == 0, m_post && m_off == DCT - 1,
         m_post && m_off == DCT, e_zig, e_row, m_post && m_off == DCT + ZZR + 1, m_loading || m_post});
    e_valid = mq[m_cur].size() != 0;
    head    = e_valid ? mq[m_cur][0] : '0;
    e_last  = e_valid && head[24] && m_cur == NCH - 1;
    chk("out_valid", out_valid, e_valid);
    if (e_valid) chk("out_beat", {out_code, out_len, out_ch, out_last}, {head[15:0], head[23:16], 2'(m_cur), e_last});
    chk("mcu_count", mcu_count, m_mcu);
    chk("err_overflow", err_overflow, m_err);

    if (input_1pix_enable) r_in1++;
    if (pix_ready) begin r_ready++; r_last_ready = cyc; end
    if (dct_enable) r_dct = cyc;
    if (dct_end_enable) r_dctend = cyc;
    if (zigzag_input_enable) r_zz = cyc;
    if (zigag_enable) begin r_zig++; r_rows = {r_rows[55:0], matrix_row}; end
    if (Huffman_start) r_huff = cyc;
    if (out_valid && out_ready) cap.push_back({out_last, out_ch, out_code});

    if (reset_n) begin
      hs = e_valid && out_ready;
      if (hs) begin
        head = mq[m_cur].pop_front();
        if (head[24]) m_cur = (m_cur == NCH - 1) ? 0 : m_cur + 1;
      end
      for (int i = 0; i < NCH; i++) begin
        if (ch_valid[i]) begin
          if (mq[i].size() < DEPTH) mq[i].push_back({ch_last[i], ch_len[i*8 +: 8], ch_code[i*16 +: 16]});
          else m_err[i] = 1'b1;
        end
      end
      if (m_post) begin
        if (m_off >= DCT + ZZR + 1 && hs && e_last) begin
          m_mcu++; m_post = 0; m_loading = enable; m_acc = 0;
        end else if (m_off < 1000) m_off++;
      end else if (m_loading) begin
        if (pix_valid) begin
          m_acc++;
          if (m_acc == 64) begin m_loading = 0; m_post = 1; m_off = 0; end
        end
      end else if (enable) begin
        m_loading = 1; m_acc = 0;
      end
    end
  end

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    enable = 0; pix_valid = 0; out_ready = 0; ch_valid = '0; ch_last = '0;
    reset_n = 0; step(); step();
    reset_n = 1; step();
  endtask

  task automatic push1(input int lane, input bit last, input int idx);
    ch_valid[lane] = 1'b1;
    ch_last[lane]  = last;
    ch_code[lane*16 +: 16] = 16'hA000 + 16'(lane) * 16'h1000 + 16'(idx);
    ch_len[lane*8 +: 8]    = 8'(lane * 16 + idx);
  endtask

  // One full MCU; pattern 1 pushes the 3/2/4 out-of-order code set.
  task automatic run_mcu(input bit toggle, input bit pattern);
    int s_in1, s_ready, s_zig, s_cap, t0, idx[3];
    bit got;
    logic [5:0] pat [6];
    logic [15:0] exp_code [9];
    logic [1:0]  exp_ch [9];
    pat = '{6'b110_000, 6'b001_000, 6'b101_000, 6'b010_010, 6'b100_000, 6'b101_101};
    exp_code = '{16'hA000, 16'hA001, 16'hA002, 16'hB000, 16'hB001, 16'hC000, 16'hC001, 16'hC002, 16'hC003};
    exp_ch = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2};
    s_in1 = r_in1; s_ready = r_ready; s_zig = r_zig; s_cap = cap.size(); t0 = cyc;
    enable = 1; pix_valid = !toggle; out_ready = 1;
    step();
    enable = 0;
    got = 0;
    for (int k = 0; k < 400; k++) begin
      step();
      if (toggle) pix_valid = ~pix_valid;
      if (r_huff > t0) begin got = 1; break; end
    end
    if (!got) chk("huff_start_timeout", 0, 1);
    pix_valid = 0;
    idx = '{0, 0, 0};
    if (!pattern) begin
      for (int i = 0; i < NCH; i++) push1(i, 1'b1, 7);
      step();
      ch_valid = '0;
    end else begin
      for (int c = 0; c < 6; c++) begin
        ch_valid = '0;
        for (int i = 0; i < NCH; i++) begin
          if (pat[c][3+i]) begin push1(i, pat[c][i], idx[i]); idx[i]++; end
        end
        step();
      end
      ch_valid = '0;
    end
    for (int k = 0; k < 100 && busy; k++) step();
    chk("mcu_finished", busy, 0);
    chk("pix_accepts", r_in1 - s_in1, 64);
    chk("load_cycles", r_ready - s_ready, toggle ? 128 : 64);
    chk("dct_after_load", r_dct - r_last_ready, 1);
    chk("dct_end_gap", r_dctend - r_dct, 15);
    chk("zz_after_dct_end", r_zz - r_dctend, 1);
    chk("zig_rows", r_rows, 64'h0001020304050607);
    chk("zig_count", r_zig - s_zig, 8);
    chk("huff_after_zz", r_huff - r_zz, 9);
    chk("codes_per_mcu", cap.size() - s_cap, pattern ? 9 : 3);
    if (pattern && cap.size() - s_cap == 9) begin
      for (int k = 0; k < 9; k++) chk("merge_order", cap[s_cap + k], {k == 8, exp_ch[k], exp_code[k]});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    bit got;
    step(); step();
    chk("reset_outputs", {pix_ready, input_1pix_enable, dct_enable, dct_end_enable, zigzag_input_enable,
        zigag_enable, matrix_row, Huffman_start, out_valid, out_code, out_len, out_ch, out_last, busy,
        mcu_count, err_overflow}, 64'd0);
    reset_n = 1; step();

    run_mcu(1'b0, 1'b0);
    run_mcu(1'b1, 1'b0);
    do_reset();
    run_mcu(1'b0, 1'b1);
    chk("mcu_count_after_t4", mcu_count, 16'd1);

    // Overflow: 17 pushes into a 16-deep lane with the output stalled.
    do_reset();
    s = cap.size();
    for (int k = 0; k < 17; k++) begin
      ch_valid = '0; push1(0, 1'b0, k); step();
    end
    ch_valid = '0; step();
    chk("ovf_flag", err_overflow, 3'b001);
    out_ready = 1;
    for (int k = 0; k < 40; k++) step();
    chk("ovf_emitted", cap.size() - s, 16);
    chk("ovf_sticky", err_overflow, 3'b001);

    // Push and pop in the same cycle on a full lane is not an overflow.
    do_reset();
    s = cap.size();
    for (int k = 0; k < 16; k++) begin
      ch_valid = '0; push1(0, 1'b0, k); step();
    end
    out_ready = 1; push1(0, 1'b0, 16); step();
    ch_valid = '0;
    for (int k = 0; k < 40; k++) step();
    chk("full_pushpop_err", err_overflow, 3'b000);
    chk("full_pushpop_emitted", cap.size() - s, 17);

    // Asynchronous reset in the middle of the DCT phase.
    do_reset();
    s = cyc;
    push1(1, 1'b0, 3); enable = 1; pix_valid = 1; step();
    ch_valid = '0; enable = 0;
    got = 0;
    for (int k = 0; k < 200; k++) begin
      step();
      if (r_dct > s) begin got = 1; break; end
    end
    if (!got) chk("dct_timeout", 0, 1);
    step(); step(); step();
    reset_n = 0; #1;
    chk("abort_outputs", {busy, out_valid, pix_ready, dct_enable, dct_end_enable, zigzag_input_enable,
                          zigag_enable, Huffman_start, mcu_count}, 0);
    step();
    reset_n = 1; pix_valid = 0; step();
    chk("abort_idle", {busy, out_valid}, 2'b00);
    run_mcu(1'b0, 1'b0);

    // Randomized traffic; the per-cycle model does all the checking.
    for (int k = 0; k < 3000; k++) begin
      enable    = ($urandom % 4) != 0;
      pix_valid = $urandom % 2;
      out_ready = ($urandom % 4) != 0;
      for (int i = 0; i < NCH; i++) begin
        ch_valid[i] = ($urandom % 6) == 0;
        ch_last[i]  = ($urandom % 3) == 0;
      end
      ch_code = 48'({$urandom, $urandom});
      ch_len  = 24'($urandom);
      step();
    end
    ch_valid = '0; enable = 0;
    for (int k = 0; k < 10; k++) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
